// File: rtl/icache_fill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : icache_fill_ctrl_pkg
// Brief  : Shared widths, bus command / MSHR state enums and entry struct.
// Rev    : 1.0
// ============================================================================
package icache_fill_ctrl_pkg;

  localparam int NUM_LINES    = 16;
  localparam int BLOCK_SIZE   = 8;
  localparam int ADDR_BITS    = 32;
  localparam int DATA_BITS    = 64;
  localparam int MEM_TAG_BITS = 4;

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int OFF_BITS = $clog2(BLOCK_SIZE);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS - OFF_BITS;
  localparam int BLK_BITS = ADDR_BITS - OFF_BITS;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_cmd_e;

  typedef enum logic [1:0] {
    MSHR_EMPTY      = 2'd0,
    MSHR_WAIT_ISSUE = 2'd1,
    MSHR_WAIT_DATA  = 2'd2
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e             state;
    logic [BLK_BITS-1:0]     blk_addr;
    logic [MEM_TAG_BITS-1:0] mem_tag;
  } mshr_entry_t;

  function automatic logic [IDX_BITS-1:0] blk_idx(input logic [BLK_BITS-1:0] blk);
    return blk[IDX_BITS-1:0];
  endfunction

  function automatic logic [TAG_BITS-1:0] blk_tag(input logic [BLK_BITS-1:0] blk);
    return blk[BLK_BITS-1:IDX_BITS];
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : icache_fill_ctrl_if
// Brief  : Fetch-miss, memory-bus and cache-write signals of the fill controller.
// Rev    : 1.0
// ============================================================================
interface icache_fill_ctrl_if;
  import icache_fill_ctrl_pkg::*;

  logic                    miss_valid;
  logic [ADDR_BITS-1:0]    miss_addr;
  logic                    miss_ready;
  logic                    squash;
  logic                    mem_grant;
  bus_cmd_e                proc2mem_command;
  logic [ADDR_BITS-1:0]    proc2mem_addr;
  logic [MEM_TAG_BITS-1:0] mem2proc_response;
  logic [DATA_BITS-1:0]    mem2proc_data;
  logic [MEM_TAG_BITS-1:0] mem2proc_tag;
  logic                    wr_en;
  logic [IDX_BITS-1:0]     wr_idx;
  logic [TAG_BITS-1:0]     wr_tag;
  logic [DATA_BITS-1:0]    wr_data;
  logic                    busy;

  // master: the fill controller itself; slave: fetch/bus/cache environment
  modport master (
    input  miss_valid, miss_addr, squash, mem_grant,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    output miss_ready, proc2mem_command, proc2mem_addr,
           wr_en, wr_idx, wr_tag, wr_data, busy
  );

  modport slave (
    output miss_valid, miss_addr, squash, mem_grant,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    input  miss_ready, proc2mem_command, proc2mem_addr,
           wr_en, wr_idx, wr_tag, wr_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/icache_fill_ctrl_mshr_entry.sv
`default_nettype none
// ============================================================================
// Module : icache_fill_ctrl_mshr_entry
// Brief  : One MSHR slot: EMPTY -> WAIT_ISSUE -> WAIT_DATA -> EMPTY.
// Rev    : 1.0
// ============================================================================
module icache_fill_ctrl_mshr_entry
  import icache_fill_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_i,
  input  logic [BLK_BITS-1:0]     alloc_blk_i,
  input  logic                    accept_i,
  input  logic [MEM_TAG_BITS-1:0] accept_tag_i,
  input  logic                    fill_i,
  input  logic                    squash_i,
  output mshr_entry_t             entry_o
);

  mshr_state_e             state_q, state_d;
  logic [BLK_BITS-1:0]     blk_q, blk_d;
  logic [MEM_TAG_BITS-1:0] tag_q, tag_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MSHR_EMPTY;
      blk_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      tag_q   <= tag_d;
    end
  end

  // Squash outranks a same-cycle bus accept, so that transaction's tag is orphaned.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    tag_d   = tag_q;
    case (state_q)
      MSHR_EMPTY: begin
        if (alloc_i) begin
          state_d = MSHR_WAIT_ISSUE;
          blk_d   = alloc_blk_i;
          tag_d   = '0;
        end
      end
      MSHR_WAIT_ISSUE: begin
        if (squash_i) begin
          state_d = MSHR_EMPTY;
        end else if (accept_i) begin
          state_d = MSHR_WAIT_DATA;
          tag_d   = accept_tag_i;
        end
      end
      MSHR_WAIT_DATA: begin
        if (fill_i) begin
          state_d = MSHR_EMPTY;
        end
      end
      default: state_d = MSHR_EMPTY;
    endcase
  end

  assign entry_o = '{state: state_q, blk_addr: blk_q, mem_tag: tag_q};

endmodule
`default_nettype wire

// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module : icache_fill_ctrl
// Brief  : I-cache miss handler: MSHR allocation/merge, bus issue, fill write.
// Rev    : 1.0
// ============================================================================
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
#(
  parameter int NUM_MSHR = 4
) (
  input  logic               clock,
  input  logic               reset,
  icache_fill_ctrl_if.master bus
);

  localparam int SEL_BITS = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  mshr_entry_t         w_entry [NUM_MSHR];
  logic [BLK_BITS-1:0] w_miss_blk;
  logic                w_hit_any;
  logic                w_free_any;
  logic                w_issue_any;
  logic                w_fill_any;
  logic                w_busy;
  logic [SEL_BITS-1:0] w_free_sel;
  logic [SEL_BITS-1:0] w_issue_sel;
  logic [SEL_BITS-1:0] w_fill_sel;
  logic                w_alloc;
  logic                w_load;
  logic                w_accept;
  logic [BLK_BITS-1:0] w_issue_blk;
  logic [BLK_BITS-1:0] w_fill_blk;

  assign w_miss_blk = bus.miss_addr[ADDR_BITS-1:OFF_BITS];

  // Descending scan so the lowest matching index is the one left selected.
  always_comb begin
    w_hit_any   = 1'b0;
    w_free_any  = 1'b0;
    w_issue_any = 1'b0;
    w_fill_any  = 1'b0;
    w_busy      = 1'b0;
    w_free_sel  = '0;
    w_issue_sel = '0;
    w_fill_sel  = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (w_entry[i].state == MSHR_EMPTY) begin
        w_free_any = 1'b1;
        w_free_sel = SEL_BITS'(i);
      end else begin
        w_busy = 1'b1;
        if (w_entry[i].blk_addr == w_miss_blk) begin
          w_hit_any = 1'b1;
        end
      end
      if (w_entry[i].state == MSHR_WAIT_ISSUE) begin
        w_issue_any = 1'b1;
        w_issue_sel = SEL_BITS'(i);
      end
      if (w_entry[i].state == MSHR_WAIT_DATA && bus.mem2proc_tag != '0 &&
          w_entry[i].mem_tag == bus.mem2proc_tag) begin
        w_fill_any = 1'b1;
        w_fill_sel = SEL_BITS'(i);
      end
    end
  end

  assign bus.miss_ready = !bus.squash && (w_hit_any || w_free_any);
  assign w_alloc        = bus.miss_valid && !bus.squash && !w_hit_any && w_free_any;
  assign w_load         = w_issue_any && bus.mem_grant;
  assign w_accept       = w_load && (bus.mem2proc_response != '0);

  generate
    for (genvar g = 0; g < NUM_MSHR; g++) begin : g_mshr
      icache_fill_ctrl_mshr_entry u_entry (
        .clk          (clock),
        .rst          (reset),
        .alloc_i      (w_alloc && (w_free_sel == SEL_BITS'(g))),
        .alloc_blk_i  (w_miss_blk),
        .accept_i     (w_accept && (w_issue_sel == SEL_BITS'(g))),
        .accept_tag_i (bus.mem2proc_response),
        .fill_i       (w_fill_any && (w_fill_sel == SEL_BITS'(g))),
        .squash_i     (bus.squash),
        .entry_o      (w_entry[g])
      );
    end
  endgenerate

  assign w_issue_blk = w_entry[w_issue_sel].blk_addr;
  assign w_fill_blk  = w_entry[w_fill_sel].blk_addr;

  assign bus.proc2mem_command = w_load ? BUS_LOAD : BUS_NONE;
  assign bus.proc2mem_addr    = w_load ? {w_issue_blk, {OFF_BITS{1'b0}}} : '0;

  assign bus.wr_en   = w_fill_any;
  assign bus.wr_idx  = w_fill_any ? blk_idx(w_fill_blk) : '0;
  assign bus.wr_tag  = w_fill_any ? blk_tag(w_fill_blk) : '0;
  assign bus.wr_data = w_fill_any ? bus.mem2proc_data : '0;
  assign bus.busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_icache_fill_ctrl
// Brief  : Directed stimulus with a per-cycle behavioural model and literal checks.
// Rev    : 1.0
// ============================================================================
module tb_icache_fill_ctrl;
  import icache_fill_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_fill_ctrl_if bus_if ();

  icache_fill_ctrl #(.NUM_MSHR(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_load   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each slot is 0 free, 1 waiting for the bus, 2 waiting for data.
  int          m_st  [4];
  logic [28:0] m_blk [4];
  logic [3:0]  m_tag [4];
  int          n_st  [4];
  logic [28:0] n_blk [4];
  logic [3:0]  n_tag [4];
  logic [28:0] e_mblk;
  logic        e_busy, e_hit, e_free, e_ready, e_cmd, e_wen;
  int          e_iss, e_fil, e_new;
  logic [31:0] e_addr;
  logic [63:0] e_idx, e_tagv, e_data;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0; m_blk[i] = '0; m_tag[i] = '0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        n_st[i] = m_st[i]; n_blk[i] = m_blk[i]; n_tag[i] = m_tag[i];
      end
      if (reset) begin
        for (int i = 0; i < 4; i++) n_st[i] = 0;
      end else begin
        e_mblk = bus_if.miss_addr[31:3];
        e_busy = 0; e_hit = 0; e_free = 0; e_iss = -1; e_fil = -1; e_new = -1;
        for (int i = 0; i < 4; i++) begin
          if (m_st[i] != 0) e_busy = 1;
          if (m_st[i] != 0 && m_blk[i] == e_mblk) e_hit = 1;
          if (m_st[i] == 0) begin
            e_free = 1;
            if (e_new < 0) e_new = i;
          end
          if (m_st[i] == 1 && e_iss < 0) e_iss = i;
          if (m_st[i] == 2 && bus_if.mem2proc_tag != 0 && m_tag[i] == bus_if.mem2proc_tag && e_fil < 0)
            e_fil = i;
        end
        e_ready = !bus_if.squash && (e_hit || e_free);
        e_cmd   = (e_iss >= 0) && bus_if.mem_grant;
        e_addr  = e_cmd ? {m_blk[e_iss], 3'b000} : 32'd0;
        e_wen   = (e_fil >= 0);
        e_idx   = e_wen ? 64'(m_blk[e_fil] % 16) : 64'd0;
        e_tagv  = e_wen ? 64'(m_blk[e_fil] / 16) : 64'd0;
        e_data  = e_wen ? bus_if.mem2proc_data : 64'd0;

        chk("m_miss_ready", bus_if.miss_ready, e_ready);
        chk("m_command", bus_if.proc2mem_command, e_cmd ? 64'd1 : 64'd0);
        chk("m_addr", bus_if.proc2mem_addr, e_addr);
        chk("m_wr_en", bus_if.wr_en, e_wen);
        chk("m_wr_idx", bus_if.wr_idx, e_idx);
        chk("m_wr_tag", bus_if.wr_tag, e_tagv);
        chk("m_wr_data", bus_if.wr_data, e_data);
        chk("m_busy", bus_if.busy, e_busy);
        if (bus_if.proc2mem_command == BUS_LOAD) n_load++;

        if (bus_if.miss_valid && e_ready && !e_hit) begin
          n_st[e_new] = 1; n_blk[e_new] = e_mblk;
        end
        if (bus_if.squash) begin
          for (int i = 0; i < 4; i++) if (m_st[i] == 1) n_st[i] = 0;
        end else if (e_cmd && bus_if.mem2proc_response != 0) begin
          n_st[e_iss] = 2; n_tag[e_iss] = bus_if.mem2proc_response;
        end
        if (e_fil >= 0) n_st[e_fil] = 0;
      end
      @(posedge clock);
      for (int i = 0; i < 4; i++) begin
        m_st[i] = n_st[i]; m_blk[i] = n_blk[i]; m_tag[i] = n_tag[i];
      end
    end
  end

  task automatic set_in(input logic mv, input logic [31:0] ma, input logic sq, input logic gr,
                        input logic [3:0] resp, input logic [3:0] mt, input logic [63:0] md);
    bus_if.miss_valid        = mv;
    bus_if.miss_addr         = ma;
    bus_if.squash            = sq;
    bus_if.mem_grant         = gr;
    bus_if.mem2proc_response = resp;
    bus_if.mem2proc_tag      = mt;
    bus_if.mem2proc_data     = md;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 64'd0);
  endtask

  int l0;

  initial begin
    idle();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_miss_ready", bus_if.miss_ready, 1);
    chk("rst_command", bus_if.proc2mem_command, 0);
    chk("rst_addr", bus_if.proc2mem_addr, 0);
    chk("rst_wr_en", bus_if.wr_en, 0);
    chk("rst_wr_idx", bus_if.wr_idx, 0);
    chk("rst_wr_tag", bus_if.wr_tag, 0);
    chk("rst_wr_data", bus_if.wr_data, 0);
    chk("rst_busy", bus_if.busy, 0);
    cyc();

    // Basic fill
    set_in(1, 32'h0000_1048, 0, 1, 4'd3, 4'd0, 64'd0);
    @(negedge clock); chk("t1_ready", bus_if.miss_ready, 1); chk("t1_no_cmd_yet", bus_if.proc2mem_command, 0);
    cyc();
    set_in(0, 32'd0, 0, 1, 4'd3, 4'd0, 64'd0);
    @(negedge clock); chk("t1_cmd", bus_if.proc2mem_command, 1); chk("t1_addr", bus_if.proc2mem_addr, 64'h1048);
    cyc();
    set_in(0, 32'd0, 0, 0, 4'd0, 4'd3, 64'hDEAD_BEEF_0123_4567);
    @(negedge clock);
    chk("t1_wr_en", bus_if.wr_en, 1); chk("t1_wr_idx", bus_if.wr_idx, 9);
    chk("t1_wr_tag", bus_if.wr_tag, 64'h20); chk("t1_wr_data", bus_if.wr_data, 64'hDEAD_BEEF_0123_4567);
    cyc();
    idle();
    @(negedge clock); chk("t1_busy_after", bus_if.busy, 0);
    cyc();

    // Merge
    l0 = n_load;
    set_in(1, 32'h2000, 0, 0, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t2_ready0", bus_if.miss_ready, 1); cyc();
    set_in(1, 32'h2004, 0, 0, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t2_ready1", bus_if.miss_ready, 1); cyc();
    set_in(0, 32'd0, 0, 1, 4'd4, 4'd0, 64'd0); cyc();
    set_in(0, 32'd0, 0, 1, 4'd0, 4'd0, 64'd0); cyc(); cyc();
    idle();
    @(negedge clock); chk("t2_one_load", 64'(n_load - l0), 1); cyc();
    set_in(0, 32'd0, 0, 0, 4'd0, 4'd4, 64'h7);
    @(negedge clock); chk("t2_fill", bus_if.wr_en, 1); cyc();
    idle();

    // Full and retry
    for (int k = 0; k < 4; k++) begin
      set_in(1, 32'h3000 + 32'(8 * k), 0, 0, 4'd0, 4'd0, 64'd0);
      @(negedge clock); chk("t3_ready_alloc", bus_if.miss_ready, 1); cyc();
    end
    set_in(1, 32'h3020, 0, 0, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t3_full_ready", bus_if.miss_ready, 0); cyc();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 32'd0, 0, 1, (k == 2) ? 4'd5 : 4'd0, 4'd0, 64'd0);
      @(negedge clock); chk("t3_retry_cmd", bus_if.proc2mem_command, 1);
      chk("t3_retry_addr", bus_if.proc2mem_addr, 64'h3000); cyc();
    end
    set_in(0, 32'd0, 0, 1, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t3_next_addr", bus_if.proc2mem_addr, 64'h3008); cyc();

    // Simultaneous fill and miss with entries 1-3 occupied
    set_in(1, 32'h3020, 0, 0, 4'd0, 4'd5, 64'h1111);
    @(negedge clock); chk("t6_fill", bus_if.wr_en, 1); chk("t6_ready0", bus_if.miss_ready, 0); cyc();
    set_in(1, 32'h3020, 0, 0, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t6_ready1", bus_if.miss_ready, 1); cyc();
    set_in(0, 32'd0, 1, 0, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t6_squash_ready", bus_if.miss_ready, 0); cyc();
    idle();
    @(negedge clock); chk("t6_busy_clear", bus_if.busy, 0); cyc();

    // Squash
    set_in(1, 32'h4000, 0, 0, 4'd0, 4'd0, 64'd0); cyc();
    set_in(1, 32'h4008, 0, 0, 4'd0, 4'd0, 64'd0); cyc();
    set_in(0, 32'd0, 0, 1, 4'd2, 4'd0, 64'd0);
    @(negedge clock); chk("t4_addr", bus_if.proc2mem_addr, 64'h4000); cyc();
    set_in(1, 32'h4010, 1, 0, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t4_squash_ready", bus_if.miss_ready, 0); cyc();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 32'd0, 0, 1, 4'd6, 4'd0, 64'd0);
      @(negedge clock); chk("t4_no_cmd", bus_if.proc2mem_command, 0); chk("t4_busy", bus_if.busy, 1); cyc();
    end
    set_in(0, 32'd0, 0, 0, 4'd0, 4'd2, 64'hA5A5_A5A5_0000_FFFF);
    @(negedge clock); chk("t4_fill", bus_if.wr_en, 1); chk("t4_idx", bus_if.wr_idx, 0);
    chk("t4_tag", bus_if.wr_tag, 64'h80); cyc();
    idle();
    @(negedge clock); chk("t4_busy_after", bus_if.busy, 0); cyc();
    set_in(1, 32'h5000, 0, 0, 4'd0, 4'd0, 64'd0); cyc();
    set_in(0, 32'd0, 1, 1, 4'd7, 4'd0, 64'd0);
    @(negedge clock); chk("t4_sq_cmd", bus_if.proc2mem_command, 1); chk("t4_sq_addr", bus_if.proc2mem_addr, 64'h5000); cyc();
    set_in(0, 32'd0, 0, 0, 4'd0, 4'd7, 64'h55);
    @(negedge clock); chk("t4_orphan_wr_en", bus_if.wr_en, 0); chk("t4_orphan_busy", bus_if.busy, 0); cyc();

    // Foreign tag and reset
    set_in(0, 32'd0, 0, 0, 4'd0, 4'd7, 64'hBEEF);
    @(negedge clock); chk("t5_foreign_wr_en", bus_if.wr_en, 0); chk("t5_foreign_data", bus_if.wr_data, 0); cyc();
    set_in(1, 32'h6000, 0, 0, 4'd0, 4'd0, 64'd0); cyc();
    set_in(1, 32'h6008, 0, 1, 4'd9, 4'd0, 64'd0); cyc();
    set_in(1, 32'h6010, 0, 0, 4'd0, 4'd0, 64'd0);
    @(negedge clock); chk("t5_busy_live", bus_if.busy, 1); cyc();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock); chk("t5_reset_busy", bus_if.busy, 0); chk("t5_reset_ready", bus_if.miss_ready, 1); cyc();
    set_in(0, 32'd0, 0, 0, 4'd0, 4'd9, 64'h99);
    @(negedge clock); chk("t5_stale_tag", bus_if.wr_en, 0); cyc();
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
